// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light sequencer.
// The optional false-start detection is enabled with the F1_FALSE_START_EN macro
// (consumed by the top module, not by this package).
package f1_pkg;

    // Sequencer phases: waiting, filling lamps, random hold, timing, result shown
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        HOLD = 3'd2,
        GO   = 3'd3,
        DONE = 3'd4
    } state_e;

    // All-ones pattern of the requested width, right-aligned in 64 bits
    function automatic logic [63:0] all_ones(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/f1_lights_seq_rise_detect.sv
// Rising-edge detector for an input already synchronous to clk.
// rise is high in the clk where d is 1 and was 0 on the previous clk.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember the previous-clk level of d
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/f1_lights_seq.sv
// F1 start-light sequencer and reaction timer.
// Fills the lamps MSB-first one per tick, holds them for a random number of
// ticks, blanks them and counts ticks until react. A saturated counter ends the
// run with timeout. Define F1_FALSE_START_EN to end a run with false_start when
// react is pressed during FILL or HOLD; without it false_start is tied low.
module f1_lights_seq
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = 10,
    parameter int DLY_W    = 7,
    parameter int RT_W     = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                trigger,
    input  logic                react,
    input  logic [DLY_W-1:0]    rnd_delay,
    output logic                en_lfsr,
    output logic [N_LIGHTS-1:0] ledr,
    output logic                busy,
    output logic [RT_W-1:0]     result,
    output logic                result_valid,
    output logic                timeout,
    output logic                false_start
);

    localparam logic [N_LIGHTS-1:0] LED_ALL = N_LIGHTS'(all_ones(N_LIGHTS));
    localparam logic [RT_W-1:0]     RT_ALL  = RT_W'(all_ones(RT_W));
    localparam logic [DLY_W-1:0]    DLY_ONE = DLY_W'(1);
    localparam logic [RT_W-1:0]     RT_ONE  = RT_W'(1);

    state_e              state_q, state_d;
    logic [N_LIGHTS-1:0] ledr_q, ledr_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [RT_W-1:0]     rt_q, rt_d;
    logic [RT_W-1:0]     result_q, result_d;
    logic                rv_q, rv_d;
    logic                timeout_q, timeout_d;
`ifdef F1_FALSE_START_EN
    logic                fs_q, fs_d;
`endif

    logic trig_rise;
    logic react_rise;

    rise_detect u_trig_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .rise  (trig_rise)
    );

    rise_detect u_react_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (react),
        .rise  (react_rise)
    );

    // State, lamp, counter and result registers; reset aborts any run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ledr_q    <= '0;
            dly_q     <= '0;
            rt_q      <= '0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            timeout_q <= 1'b0;
`ifdef F1_FALSE_START_EN
            fs_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ledr_q    <= ledr_d;
            dly_q     <= dly_d;
            rt_q      <= rt_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            timeout_q <= timeout_d;
`ifdef F1_FALSE_START_EN
            fs_q      <= fs_d;
`endif
        end
    end

    // Next-state and next-register logic; react has priority over a same-clk tick
    always_comb begin
        state_d   = state_q;
        ledr_d    = ledr_q;
        dly_d     = dly_q;
        rt_d      = rt_q;
        result_d  = result_q;
        rv_d      = 1'b0;
        timeout_d = timeout_q;
`ifdef F1_FALSE_START_EN
        fs_d      = fs_q;
`endif
        unique case (state_q)
            IDLE: begin
                ledr_d = '0;
                if (trig_rise) begin
                    state_d = FILL;
                end
            end
            FILL: begin
`ifdef F1_FALSE_START_EN
                if (react_rise) begin
                    state_d  = DONE;
                    fs_d     = 1'b1;
                    result_d = '0;
                    rv_d     = 1'b1;
                    ledr_d   = LED_ALL;
                end else
`endif
                if (tick) begin
                    if (ledr_q == LED_ALL) begin
                        state_d = HOLD;
                        dly_d   = (rnd_delay == '0) ? DLY_ONE : rnd_delay;
                    end else begin
                        ledr_d = {1'b1, ledr_q[N_LIGHTS-1:1]};
                    end
                end
            end
            HOLD: begin
                ledr_d = LED_ALL;
`ifdef F1_FALSE_START_EN
                if (react_rise) begin
                    state_d  = DONE;
                    fs_d     = 1'b1;
                    result_d = '0;
                    rv_d     = 1'b1;
                end else
`endif
                if (tick) begin
                    if (dly_q == DLY_ONE) begin
                        state_d = GO;
                        ledr_d  = '0;
                        rt_d    = '0;
                    end else begin
                        dly_d = dly_q - DLY_ONE;
                    end
                end
            end
            GO: begin
                ledr_d = '0;
                if (react_rise) begin
                    state_d   = DONE;
                    result_d  = rt_q;
                    rv_d      = 1'b1;
                    timeout_d = 1'b0;
                end else if (tick) begin
                    if (rt_q == RT_ALL) begin
                        state_d   = DONE;
                        result_d  = RT_ALL;
                        rv_d      = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        rt_d = rt_q + RT_ONE;
                    end
                end
            end
            DONE: begin
                if (trig_rise) begin
                    state_d   = FILL;
                    ledr_d    = '0;
                    timeout_d = 1'b0;
`ifdef F1_FALSE_START_EN
                    fs_d      = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                ledr_d  = '0;
            end
        endcase
    end

    assign ledr         = ledr_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q == FILL) || (state_q == HOLD) || (state_q == GO);
    assign en_lfsr      = (state_q != HOLD);
`ifdef F1_FALSE_START_EN
    assign false_start  = fs_q;
`else
    assign false_start  = 1'b0;
`endif

endmodule

// File: tb/tb_f1_lights_seq.sv
// Bench for f1_lights_seq: directed and randomized runs on a 14-bit-timer
// instance (a) and a 4-bit-timer instance (b) for saturation.
module tb_f1_lights_seq;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       trigger_a = 1'b0;
    logic       react_a = 1'b0;
    logic       trigger_b = 1'b0;
    logic       react_b = 1'b0;
    logic [6:0] rnd_delay = '0;

    logic          en_lfsr_a, busy_a, rv_a, timeout_a, fs_a;
    logic [N-1:0]  ledr_a;
    logic [13:0]   result_a;
    logic          en_lfsr_b, busy_b, rv_b, timeout_b, fs_b;
    logic [N-1:0]  ledr_b;
    logic [3:0]    result_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    f1_lights_seq #(.N_LIGHTS(N), .DLY_W(7), .RT_W(14)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .trigger      (trigger_a),
        .react        (react_a),
        .rnd_delay    (rnd_delay),
        .en_lfsr      (en_lfsr_a),
        .ledr         (ledr_a),
        .busy         (busy_a),
        .result       (result_a),
        .result_valid (rv_a),
        .timeout      (timeout_a),
        .false_start  (fs_a)
    );

    f1_lights_seq #(.N_LIGHTS(N), .DLY_W(7), .RT_W(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .trigger      (trigger_b),
        .react        (react_b),
        .rnd_delay    (rnd_delay),
        .en_lfsr      (en_lfsr_b),
        .ledr         (ledr_b),
        .busy         (busy_b),
        .result       (result_b),
        .result_valid (rv_b),
        .timeout      (timeout_b),
        .false_start  (fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Lamp pattern after k fill ticks: top k bits lit
    function automatic logic [31:0] fill_pat(input int k);
        if (k <= 0) return 32'd0;
        return ((32'd1 << k) - 32'd1) << (N - k);
    endfunction

    // Number of hold ticks the player waits for a sampled delay value
    function automatic int hold_len(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_gap(input int g);
        repeat (g - 1) clk1();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    function automatic int pick_gap(input bit rnd);
        return rnd ? int'($urandom_range(1, 5)) : 4;
    endfunction

    task automatic pulse_trig_a();
        trigger_a = 1'b1;
        clk1();
        trigger_a = 1'b0;
    endtask

    task automatic pulse_react_a();
        react_a = 1'b1;
        clk1();
        react_a = 1'b0;
    endtask

    // Trigger instance a, check the fill, enter HOLD with delay hv
    task automatic start_run_a(input int hv, input bit rnd);
        pulse_trig_a();
        chk("fill0_ledr", 32'(ledr_a), 32'd0);
        chk("fill0_busy", 32'(busy_a), 32'd1);
        for (int k = 1; k <= N; k++) begin
            tick_gap(pick_gap(rnd));
            chk("fill_ledr", 32'(ledr_a), fill_pat(k));
            chk("fill_en_lfsr", 32'(en_lfsr_a), 32'd1);
        end
        rnd_delay = 7'(hv);
        tick_gap(pick_gap(rnd));
        rnd_delay = 7'($urandom);
        chk("hold_ledr", 32'(ledr_a), fill_pat(N));
        chk("hold_en_lfsr", 32'(en_lfsr_a), 32'd0);
    endtask

    // Walk through HOLD: lamps stay lit until the last hold tick blanks them
    task automatic hold_to_go_a(input int hv, input bit rnd);
        for (int i = 1; i < hold_len(hv); i++) begin
            tick_gap(pick_gap(rnd));
            chk("hold_lit", 32'(ledr_a), fill_pat(N));
        end
        tick_gap(pick_gap(rnd));
        chk("go_ledr", 32'(ledr_a), 32'd0);
        chk("go_busy", 32'(busy_a), 32'd1);
    endtask

    initial begin
        int hv;
        int rt;

        // Reset state
        repeat (3) clk1();
        chk("rst_ledr", 32'(ledr_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_result", 32'(result_a), 32'd0);
        chk("rst_rv", 32'(rv_a), 32'd0);
        chk("rst_timeout", 32'(timeout_a), 32'd0);
        chk("rst_fs", 32'(fs_a), 32'd0);
        chk("rst_en_lfsr", 32'(en_lfsr_a), 32'd1);
        chk("rst_b_ledr", 32'(ledr_b), 32'd0);
        rst_n = 1'b1;
        clk1();
        chk("idle_ledr", 32'(ledr_a), 32'd0);

        // Fill with fixed tick spacing, delay 5, trigger ignored in HOLD
        start_run_a(5, 1'b0);
        tick_gap(4);
        chk("hold1_ledr", 32'(ledr_a), fill_pat(N));
        pulse_trig_a();
        chk("hold_trig_ign_ledr", 32'(ledr_a), fill_pat(N));
        chk("hold_trig_ign_busy", 32'(busy_a), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick_gap(4);
            chk("hold_n_ledr", 32'(ledr_a), fill_pat(N));
        end
        tick_gap(4);
        chk("hold5_go_ledr", 32'(ledr_a), 32'd0);
        chk("hold5_go_busy", 32'(busy_a), 32'd1);

        // React 37 ticks into GO, trigger in GO ignored
        repeat (20) tick_gap(4);
        pulse_trig_a();
        repeat (17) tick_gap(4);
        chk("go_rv_idle", 32'(rv_a), 32'd0);
        chk("go_busy37", 32'(busy_a), 32'd1);
        react_a = 1'b1;
        clk1();
        chk("r37_result", 32'(result_a), 32'd37);
        chk("r37_rv", 32'(rv_a), 32'd1);
        chk("r37_busy", 32'(busy_a), 32'd0);
        chk("r37_ledr", 32'(ledr_a), 32'd0);
        chk("r37_timeout", 32'(timeout_a), 32'd0);
        chk("done_en_lfsr", 32'(en_lfsr_a), 32'd1);
        clk1();
        chk("r37_rv_pulse", 32'(rv_a), 32'd0);
        tick_gap(4);
        chk("r37_held", 32'(result_a), 32'd37);
        react_a = 1'b0;
        clk1();

        // Randomized runs: random delay, spacing and reaction time
        for (int r = 0; r < 4; r++) begin
            hv = int'($urandom_range(0, 12));
            rt = (r == 0) ? 0 : int'($urandom_range(1, 50));
            start_run_a(hv, 1'b1);
            hold_to_go_a(hv, 1'b1);
            repeat (rt) tick_gap(pick_gap(1'b1));
            pulse_react_a();
            chk("rnd_result", 32'(result_a), 32'(rt));
            chk("rnd_rv", 32'(rv_a), 32'd1);
            chk("rnd_busy", 32'(busy_a), 32'd0);
        end

        // Zero delay behaves as one; react coincident with tick at rt=20
        start_run_a(0, 1'b1);
        hold_to_go_a(0, 1'b1);
        repeat (20) tick_gap(pick_gap(1'b1));
        react_a = 1'b1;
        tick = 1'b1;
        clk1();
        react_a = 1'b0;
        tick = 1'b0;
        chk("coinc_result", 32'(result_a), 32'd20);
        chk("coinc_rv", 32'(rv_a), 32'd1);

        // Saturation on the 4-bit instance
        rnd_delay = 7'd2;
        trigger_b = 1'b1;
        clk1();
        trigger_b = 1'b0;
        repeat (N + 1) tick_gap(4);
        chk("b_hold_ledr", 32'(ledr_b), fill_pat(N));
        repeat (2) tick_gap(4);
        chk("b_go_ledr", 32'(ledr_b), 32'd0);
        repeat (15) tick_gap(4);
        chk("b_rt15_busy", 32'(busy_b), 32'd1);
        chk("b_rt15_timeout", 32'(timeout_b), 32'd0);
        tick_gap(4);
        chk("b_sat_result", 32'(result_b), 32'hF);
        chk("b_sat_timeout", 32'(timeout_b), 32'd1);
        chk("b_sat_rv", 32'(rv_b), 32'd1);
        chk("b_sat_busy", 32'(busy_b), 32'd0);
        chk("a_untouched", 32'(result_a), 32'd20);
        clk1();
        chk("b_sat_rv_pulse", 32'(rv_b), 32'd0);
        chk("b_timeout_held", 32'(timeout_b), 32'd1);
        trigger_b = 1'b1;
        clk1();
        trigger_b = 1'b0;
        chk("b_retrig_timeout", 32'(timeout_b), 32'd0);
        chk("b_retrig_busy", 32'(busy_b), 32'd1);
        chk("b_retrig_result", 32'(result_b), 32'hF);

        // Asynchronous reset mid-fill
        pulse_trig_a();
        repeat (3) tick_gap(4);
        chk("pre_rst_ledr", 32'(ledr_a), fill_pat(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ledr", 32'(ledr_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_result", 32'(result_a), 32'd0);
        chk("arst_b_result", 32'(result_b), 32'd0);
        clk1();
        clk1();
        rst_n = 1'b1;
        clk1();
        chk("post_rst_idle", 32'(busy_a), 32'd0);

        // React during HOLD
        start_run_a(3, 1'b0);
        pulse_react_a();
`ifdef F1_FALSE_START_EN
        chk("fs_flag", 32'(fs_a), 32'd1);
        chk("fs_result", 32'(result_a), 32'd0);
        chk("fs_rv", 32'(rv_a), 32'd1);
        chk("fs_ledr", 32'(ledr_a), fill_pat(N));
        chk("fs_busy", 32'(busy_a), 32'd0);
        tick_gap(4);
        chk("fs_ledr_held", 32'(ledr_a), fill_pat(N));
        pulse_trig_a();
        chk("fs_cleared", 32'(fs_a), 32'd0);
        chk("fs_refill_ledr", 32'(ledr_a), 32'd0);
        repeat (2) tick_gap(4);
        pulse_react_a();
        chk("fs_fill_flag", 32'(fs_a), 32'd1);
        chk("fs_fill_ledr", 32'(ledr_a), fill_pat(N));
`else
        chk("nofs_ledr", 32'(ledr_a), fill_pat(N));
        chk("nofs_busy", 32'(busy_a), 32'd1);
        chk("nofs_flag", 32'(fs_a), 32'd0);
        chk("nofs_rv", 32'(rv_a), 32'd0);
        hold_to_go_a(3, 1'b0);
        repeat (6) tick_gap(4);
        pulse_react_a();
        chk("nofs_result", 32'(result_a), 32'd6);
        chk("nofs_flag_end", 32'(fs_a), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
